// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared types and default system address map
// for the Ibex data-bus demultiplexer.
package data_bus_pkg;

  localparam int unsigned DBD_N_SLV = 5;
  localparam int unsigned DBD_AW    = 32;

  localparam logic [31:0] RAM_BASE    = 32'h3000;
  localparam logic [31:0] RAM_SIZE    = 32'h1000;
  localparam logic [31:0] IO_BASE     = 32'h4000;
  localparam logic [31:0] IO_SIZE     = 32'h0C;
  localparam logic [31:0] UART0_BASE  = 32'h400C;
  localparam logic [31:0] UART0_SIZE  = 32'h10;
  localparam logic [31:0] TIMER_BASE  = 32'h401C;
  localparam logic [31:0] TIMER_SIZE  = 32'h60;
  localparam logic [31:0] TIMER1_BASE = TIMER_BASE + TIMER_SIZE;
  localparam logic [31:0] TIMER1_SIZE = 32'h60;

  localparam logic [DBD_N_SLV*DBD_AW-1:0] DBD_SLV_BASE = {
    TIMER1_BASE, TIMER_BASE, UART0_BASE, IO_BASE, RAM_BASE
  };
  localparam logic [DBD_N_SLV*DBD_AW-1:0] DBD_SLV_SIZE = {
    TIMER1_SIZE, TIMER_SIZE, UART0_SIZE, IO_SIZE, RAM_SIZE
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR
  } dbd_state_e;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/data_bus_addr_dec.sv
// data_bus_addr_dec: priority address decoder, lowest index wins,
// returns one-hot hit and offset into the hit region.
module data_bus_addr_dec
  import data_bus_pkg::*;
#(
  parameter int unsigned N_SLV = DBD_N_SLV,
  parameter int unsigned AW    = DBD_AW,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = DBD_SLV_BASE,
  parameter logic [N_SLV*AW-1:0] SLV_SIZE = DBD_SLV_SIZE
) (
  input  logic [AW-1:0]    addr,
  output logic [N_SLV-1:0] hit,
  output logic             any_hit,
  output logic [AW-1:0]    offset
);

  logic [N_SLV-1:0] in_rng;

  // AW+1 bit compare keeps top-of-space regions from wrapping
  always_comb begin
    in_rng = '0;
    for (int k = 0; k < N_SLV; k++) begin
      in_rng[k] = (SLV_SIZE[k*AW +: AW] != '0)
        && ({1'b0, addr} >= {1'b0, SLV_BASE[k*AW +: AW]})
        && ({1'b0, addr} < ({1'b0, SLV_BASE[k*AW +: AW]}
                          + {1'b0, SLV_SIZE[k*AW +: AW]}));
    end
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    hit    = '0;
    offset = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (in_rng[k] && !found) begin
        hit[k] = 1'b1;
        offset = addr - SLV_BASE[k*AW +: AW];
        found  = 1'b1;
      end
    end
  end

  assign any_hit = |in_rng;

endmodule

// File: rtl/data_bus_demux.sv
// data_bus_demux: Ibex data port to N memory-mapped slaves,
// with unmapped-address and slave-timeout error responses.
module data_bus_demux
  import data_bus_pkg::*;
#(
  parameter int unsigned N_SLV = DBD_N_SLV,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = DBD_AW,
  parameter int unsigned SW    = DW / 8,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = DBD_SLV_BASE,
  parameter logic [N_SLV*AW-1:0] SLV_SIZE = DBD_SLV_SIZE,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [SW-1:0]       data_be,
  input  logic [AW-1:0]       data_addr,
  input  logic [DW-1:0]       data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DW-1:0]       data_rdata,
  output logic                data_err,
  output logic [N_SLV-1:0]    slv_req,
  output logic                slv_we,
  output logic [SW-1:0]       slv_be,
  output logic [AW-1:0]       slv_addr,
  output logic [DW-1:0]       slv_wdata,
  input  logic [N_SLV-1:0]    slv_rvalid,
  input  logic [N_SLV*DW-1:0] slv_rdata,
  output logic                stray
);

  localparam int unsigned CW   = cnt_width(TIMEOUT);
  localparam int unsigned SELW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  dbd_state_e state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stray_q, stray_d;

  logic [N_SLV-1:0] hit;
  logic             any_hit;
  logic [AW-1:0]    offset;
  logic [SELW-1:0]  hit_idx;
  logic [N_SLV-1:0] sel_oh;
  logic             rsp_ok;
  logic [DW-1:0]    sel_rdata;

  logic             gnt_c, rvalid_c, err_c, accept;
  logic [N_SLV-1:0] req_c;
  logic [DW-1:0]    rdata_c;

  data_bus_addr_dec #(
    .N_SLV    (N_SLV),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_SIZE (SLV_SIZE)
  ) u_dec (
    .addr    (data_addr),
    .hit     (hit),
    .any_hit (any_hit),
    .offset  (offset)
  );

  always_comb begin
    hit_idx   = '0;
    sel_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (hit[k]) hit_idx = SELW'(k);
      if (SELW'(k) == sel_q) sel_rdata = slv_rdata[k*DW +: DW];
    end
  end

  assign sel_oh = (state_q == ST_WAIT) ? (N_SLV'(1) << sel_q) : '0;
  assign rsp_ok = |(slv_rvalid & sel_oh);
  assign stray_d = |(slv_rvalid & ~sel_oh);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    gnt_c    = 1'b0;
    req_c    = '0;
    rvalid_c = 1'b0;
    err_c    = 1'b0;
    rdata_c  = '0;
    accept   = 1'b0;
    unique case (state_q)
      ST_IDLE: accept = 1'b1;
      ST_WAIT: begin
        if (rsp_ok) begin
          rvalid_c = 1'b1;
          rdata_c  = sel_rdata;
          accept   = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ERR: begin
        rvalid_c = 1'b1;
        err_c    = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // grant path shared by IDLE and the completing WAIT cycle
    if (accept && data_req) begin
      gnt_c = 1'b1;
      req_c = hit;
      if (any_hit) begin
        state_d = ST_WAIT;
        sel_d   = hit_idx;
        cnt_d   = '0;
      end else begin
        state_d = ST_ERR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end

  assign data_gnt    = gnt_c & ~rst;
  assign slv_req     = rst ? '0 : req_c;
  assign data_rvalid = rvalid_c & ~rst;
  assign data_err    = err_c & ~rst;
  assign data_rdata  = rst ? '0 : rdata_c;

  assign slv_we    = data_we;
  assign slv_be    = data_be;
  assign slv_addr  = offset;
  assign slv_wdata = data_wdata;
  assign stray     = stray_q;

endmodule

// File: tb/tb_data_bus_demux.sv
// tb_data_bus_demux: directed + randomized bench with a
// transaction-level reference model of the demux.
module tb_data_bus_demux;

  localparam int TO = 4;
  localparam logic [31:0] B0 = 32'h3000, S0 = 32'h1000;
  localparam logic [31:0] B1 = 32'h4000, S1 = 32'h0C;
  localparam logic [31:0] B2 = 32'h400C, S2 = 32'h10;
  localparam logic [31:0] B3 = 32'h401C, S3 = 32'h60;
  localparam logic [31:0] B4 = 32'h407C, S4 = 32'h60;

  logic [31:0] base_a [5] = '{B0, B1, B2, B3, B4};
  logic [31:0] size_a [5] = '{S0, S1, S2, S3, S4};

  logic         clk = 1'b0;
  logic         rst;
  logic         data_req, data_we;
  logic [3:0]   data_be;
  logic [31:0]  data_addr, data_wdata;
  logic         data_gnt, data_rvalid, data_err;
  logic [31:0]  data_rdata;
  logic [4:0]   slv_req;
  logic         slv_we;
  logic [3:0]   slv_be;
  logic [31:0]  slv_addr, slv_wdata;
  logic [4:0]   slv_rvalid;
  logic [159:0] slv_rdata;
  logic         stray;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_demux #(
    .N_SLV    (5),
    .DW       (32),
    .AW       (32),
    .SW       (4),
    .SLV_BASE ({B4, B3, B2, B1, B0}),
    .SLV_SIZE ({S4, S3, S2, S1, S0}),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .data_err    (data_err),
    .slv_req     (slv_req),
    .slv_we      (slv_we),
    .slv_be      (slv_be),
    .slv_addr    (slv_addr),
    .slv_wdata   (slv_wdata),
    .slv_rvalid  (slv_rvalid),
    .slv_rdata   (slv_rdata),
    .stray       (stray)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 5; k++) begin
      if (size_a[k] != 0 && longint'(a) >= longint'(base_a[k])
          && longint'(a) < longint'(base_a[k]) + longint'(size_a[k]))
        return k;
    end
    return -1;
  endfunction

  // Reference model: one outstanding transaction, aged in cycles
  bit   m_busy = 0;
  int   m_slv = 0;
  int   m_waited = 0;
  bit   m_err_due = 0;
  bit   m_stray_exp = 0;
  logic gnt_seen = 0;

  always @(negedge clk) begin
    int          h;
    logic        e_gnt, e_rv, e_err, take, nxt_stray;
    logic [31:0] e_rd, e_off;
    logic [4:0]  e_req, awaited;
    h = decode(data_addr);
    e_off = (h >= 0) ? data_addr - base_a[h] : 32'h0;
    e_gnt = 0; e_rv = 0; e_err = 0; take = 0;
    e_rd = 0; e_req = 0; awaited = 0;
    if (!rst) begin
      if (m_err_due) begin
        e_rv = 1; e_err = 1;
      end else if (m_busy) begin
        awaited[m_slv] = 1'b1;
        if (slv_rvalid[m_slv]) begin
          e_rv = 1;
          e_rd = slv_rdata[m_slv*32 +: 32];
          take = 1;
        end
      end else begin
        take = 1;
      end
      if (take && data_req) begin
        e_gnt = 1;
        if (h >= 0) e_req[h] = 1'b1;
      end
    end
    chk("gnt", 32'(data_gnt), 32'(e_gnt));
    chk("slv_req", 32'(slv_req), 32'(e_req));
    chk("rvalid", 32'(data_rvalid), 32'(e_rv));
    if (e_rv) begin
      chk("err", 32'(data_err), 32'(e_err));
      chk("rdata", data_rdata, e_rd);
    end
    chk("slv_addr", slv_addr, e_off);
    chk("slv_bcast", {slv_we, slv_be, slv_wdata[26:0]},
        {data_we, data_be, data_wdata[26:0]});
    chk("stray", 32'(stray), rst ? 32'h0 : 32'(m_stray_exp));
    nxt_stray = !rst && |(slv_rvalid & ~awaited);
    if (rst) begin
      m_busy = 0; m_err_due = 0; m_waited = 0;
    end else begin
      if (m_err_due) m_err_due = 0;
      else if (m_busy) begin
        if (slv_rvalid[m_slv]) m_busy = 0;
        else begin
          m_waited++;
          if (m_waited == TO) begin
            m_busy = 0;
            m_err_due = 1;
          end
        end
      end
      if (e_gnt) begin
        if (h >= 0) begin
          m_busy = 1; m_slv = h; m_waited = 0;
        end else m_err_due = 1;
      end
    end
    m_stray_exp = nxt_stray;
    gnt_seen = data_gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic quiet();
    data_req = 0;
    slv_rvalid = '0;
  endtask

  task automatic host(input logic we, input logic [31:0] a,
                      input logic [3:0] be);
    data_req = 1; data_we = we; data_addr = a; data_be = be;
    data_wdata = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 5);
    if (k == 5) return $urandom;
    case ($urandom_range(0, 3))
      0: return base_a[k] + ($urandom % size_a[k]);
      1: return base_a[k];
      2: return base_a[k] + size_a[k] - 1;
      default: return base_a[k] + size_a[k];
    endcase
  endfunction

  initial begin
    rst = 1; data_req = 0; data_we = 0; data_be = 0;
    data_addr = 0; data_wdata = 0; slv_rvalid = 0; slv_rdata = '0;
    samp();
    chk("rst_stray", 32'(stray), 32'h0);
    chk("rst_rvalid", 32'(data_rvalid), 32'h0);
    tick(); tick();
    rst = 0;

    // RAM read, one-cycle slave
    tick(); host(0, 32'h3010, 4'hF);
    samp();
    chk("ram_req", 32'(slv_req), 32'h1);
    chk("ram_off", slv_addr, 32'h10);
    tick(); data_req = 0; slv_rvalid = 5'b00001;
    slv_rdata[31:0] = 32'hDEADBEEF;
    samp();
    chk("ram_rv", 32'(data_rvalid), 32'h1);
    chk("ram_rd", data_rdata, 32'hDEADBEEF);
    chk("ram_err", 32'(data_err), 32'h0);

    // UART0 write
    tick(); quiet(); host(1, 32'h4010, 4'b0011);
    samp();
    chk("uart_req", 32'(slv_req), 32'h4);
    chk("uart_off", slv_addr, 32'h4);
    chk("uart_be", 32'(slv_be), 32'h3);
    tick(); data_req = 0; slv_rvalid = 5'b00100;
    samp();
    chk("uart_rv", 32'(data_rvalid), 32'h1);
    chk("uart_err", 32'(data_err), 32'h0);

    // unmapped accesses, below RAM and just past Timer1
    for (int i = 0; i < 2; i++) begin
      tick(); quiet(); host(0, i == 0 ? 32'h2FFC : 32'h40DC, 4'hF);
      samp();
      chk("unm_gnt", 32'(data_gnt), 32'h1);
      chk("unm_req", 32'(slv_req), 32'h0);
      tick(); data_req = 0; slv_rdata = {5{32'h5A5A5A5A}};
      samp();
      chk("unm_rv", 32'(data_rvalid), 32'h1);
      chk("unm_err", 32'(data_err), 32'h1);
      chk("unm_rd", data_rdata, 32'h0);
    end

    // silent slave: timeout, then a late stray answer
    tick(); quiet(); host(0, 32'h3000, 4'hF);
    samp();
    chk("to_gnt", 32'(data_gnt), 32'h1);
    for (int i = 1; i <= TO; i++) begin
      tick(); data_req = 0;
      samp();
      chk("to_wait", 32'(data_rvalid), 32'h0);
    end
    tick();
    samp();
    chk("to_rv", 32'(data_rvalid), 32'h1);
    chk("to_err", 32'(data_err), 32'h1);
    chk("to_rd", data_rdata, 32'h0);
    tick();
    samp();
    tick(); slv_rvalid = 5'b00001;
    samp();
    chk("late_rv", 32'(data_rvalid), 32'h0);
    tick(); slv_rvalid = 0;
    samp();
    chk("late_stray", 32'(stray), 32'h1);

    // back-to-back: RAM response cycle grants Timer request
    tick(); host(0, 32'h3004, 4'hF);
    samp();
    tick(); host(0, 32'h401C, 4'hF);
    slv_rvalid = 5'b00001; slv_rdata[31:0] = 32'h11111111;
    samp();
    chk("b2b_rv1", data_rdata, 32'h11111111);
    chk("b2b_gnt", 32'(data_gnt), 32'h1);
    chk("b2b_req", 32'(slv_req), 32'h8);
    chk("b2b_off", slv_addr, 32'h0);
    tick(); data_req = 0; slv_rvalid = 5'b01000;
    slv_rdata[127:96] = 32'h22222222;
    samp();
    chk("b2b_rv2", data_rdata, 32'h22222222);

    // reset mid-WAIT
    tick(); quiet(); host(0, 32'h3008, 4'hF);
    samp();
    tick(); rst = 1; slv_rvalid = 5'b00001;
    #1;
    chk("rw_gnt", 32'(data_gnt), 32'h0);
    chk("rw_rv", 32'(data_rvalid), 32'h0);
    chk("rw_req", 32'(slv_req), 32'h0);
    chk("rw_rd", data_rdata, 32'h0);
    tick(); rst = 0; slv_rvalid = 0; host(0, 32'h4000, 4'hF);
    samp();
    chk("rw2_req", 32'(slv_req), 32'h2);
    tick(); data_req = 0; slv_rvalid = 5'b00010;
    slv_rdata[63:32] = 32'hCAFE0001;
    samp();
    chk("rw2_rd", data_rdata, 32'hCAFE0001);
    tick(); quiet();

    // randomized traffic with random slave answers and strays
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!data_req || gnt_seen) begin
        if ($urandom_range(0, 1) == 1) begin
          host($urandom_range(0, 1) == 1, rand_addr(), 4'($urandom));
        end else data_req = 0;
      end
      for (int k = 0; k < 5; k++) begin
        slv_rvalid[k] = ($urandom_range(0, 99) < 30);
        slv_rdata[k*32 +: 32] = $urandom;
      end
    end
    tick(); quiet();
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_demux.md
# data_bus_demux

Parametrised data-bus fabric between the Ibex data port and N memory-mapped slaves: RAM, IO module, UART0, Timer, Timer1 and later peripherals. It decodes each request against a parametrised base/size map and forwards it to exactly one slave on a RAMbus-style req/rvalid channel. It returns the response with `data_gnt`/`data_rvalid`/`data_err` semantics. It also generates error responses for unmapped addresses and for slaves that never answer. It replaces per-SoC hand-written address muxing, and adds channel count, timeout and error handling.

## Interface
- `N_SLV`, 5: number of slave channels.
- `DW`, 32: data width.
- `AW`, 32: address width.
- `SW`, 4: byte-enable width, equal to DW/8.
- `SLV_BASE`, {32'h401C+32'h60, 32'h401C, 32'h400C, 32'h4000, 32'h3000}: packed N_SLV×AW base addresses; index 0 is the LSB slice.
- `SLV_SIZE`, {32'h60, 32'h60, 32'h10, 32'h0C, 32'h1000}: packed N_SLV×AW region sizes in bytes.
- `TIMEOUT`, 255: maximum cycles spent waiting for slave rvalid. Range 1..65535.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_req`  in  1  host request.
- `data_we`  in  1  host write.
- `data_be`  in  SW  host byte enables.
- `data_addr`  in  AW  host byte address.
- `data_wdata`  in  DW  host write data.
- `data_gnt`  out  1  request accepted.
- `data_rvalid`  out  1  response valid, one pulse per granted request.
- `data_rdata`  out  DW  read data; 0 on error.
- `data_err`  out  1  error response, qualified by `data_rvalid`.
- `slv_req`  out  N_SLV  one-hot request strobe.
- `slv_we`  out  1  write, broadcast to all slaves.
- `slv_be`  out  SW  byte enables, broadcast.
- `slv_addr`  out  AW  offset `data_addr - SLV_BASE[k]`; 0 when no hit.
- `slv_wdata`  out  DW  write data, broadcast.
- `slv_rvalid`  in  N_SLV  per-slave response valid.
- `slv_rdata`  in  N_SLV×DW  per-slave read data.
- `stray`  out  1  one-cycle pulse: an rvalid arrived from a slave that was not awaited.

## Operation
- Decode rule: slave k hits when `SLV_BASE[k] <= data_addr < SLV_BASE[k]+SLV_SIZE[k]`. The comparison is done in AW+1 bits, so a region reaching the top of the address space does not wrap.
- Overlapping regions: the lowest index wins.
- SLV_SIZE 0 disables that channel.
- FSM states: IDLE, WAIT, ERR.
- IDLE with `data_req`, hit k:
  - `data_gnt`=1 and `slv_req[k]`=1 combinationally in the same cycle.
  - Register `sel`=k and clear the timeout counter.
  - Next state: WAIT.
- IDLE with `data_req`, no hit: `data_gnt`=1, no `slv_req`, next state ERR.
- ERR: `data_rvalid`=1, `data_err`=1, `data_rdata`=0 for one cycle, then IDLE. No grant is issued in ERR.
- WAIT, `slv_rvalid[sel]`=1:
  - `data_rvalid`=1, `data_err`=0, `data_rdata`=`slv_rdata[sel]`, combinationally.
  - In the same cycle a new `data_req` is decoded and granted exactly as in IDLE, giving back-to-back throughput.
- WAIT, no rvalid: increment the counter. When counter==TIMEOUT-1 with no rvalid, the next cycle gives `data_rvalid`=1, `data_err`=1, `data_rdata`=0, then IDLE. That is a timeout response TIMEOUT+1 cycles after the grant.
- A response exactly on the timeout cycle is treated as a normal response; the rvalid wins.
- Ignored rvalids: any `slv_rvalid` bit outside WAIT/sel is ignored and pulses `stray` on the next cycle. This includes a late answer after a timeout.
- Writes: writes also wait for slave rvalid. The slave acknowledges a write with rvalid; rdata is don't-care and forwarded as is.
- At most one outstanding transaction.

## Timing
- Reset values: state IDLE, `sel`=0, counter=0, `stray`=0.
- All combinational outputs are forced to 0 while `rst`=1: `data_gnt`, `slv_req`, `data_rvalid`, `data_err`, `data_rdata`.
- Reset asserted mid-WAIT: the transaction is dropped with no response. The host is reset by the same signal.
- Zero-wait slave: grant at cycle t, rvalid at t+1 gives host rvalid at t+1.
- Unmapped access: grant at t, error response at t+1.
- Request-to-grant latency: 0 cycles in IDLE, or on the final cycle of WAIT; otherwise the request stalls.

## Structure
- Package `data_bus_pkg`:
  - Default address map localparams, derived from the system map.
  - State enum `dbd_state_e`.
  - `TIMEOUT` counter width function, `$clog2(TIMEOUT+1)`.
- Sub-module `data_bus_addr_dec`: combinational decoder producing a priority one-hot `hit`, `any_hit` and the offset address. It is instantiated once.

## Test plan
- Read from RAM, addr 0x3010, slave rvalid 1 cycle later with rdata 0xDEADBEEF:
  - `slv_req`=00001, `slv_addr`=0x10.
  - Host sees rvalid with 0xDEADBEEF, err=0.
- Write to UART0 at 0x4010, be=4'b0011:
  - `slv_req[2]` is asserted with offset 0x4 and `slv_be`=0011.
  - The slave rvalid produces a host rvalid with err=0.
- Access 0x2FFC, and 0x40DC (Timer1 end):
  - Each is granted with no `slv_req`.
  - Each gets rvalid+err at t+1 with rdata=0.
- TIMEOUT=4 and a silent slave:
  - Error response 5 cycles after the grant.
  - A late rvalid 2 cycles later pulses `stray` only.
- Back-to-back: on the RAM rvalid cycle, a new request to the Timer at 0x401C is granted in the same cycle. Two responses follow, in order.
- `rst` pulse during WAIT:
  - Outputs go to 0 immediately.
  - After release the first request is serviced normally.
